// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a direct-mapped instruction cache in front of program memory.
// Hits return in one cycle; misses go through a valid/ready read to the memory controller.
module fetcher_icache #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int A        = PROGRAM_MEM_ADDR_BITS;
  localparam int D        = PROGRAM_MEM_DATA_BITS;
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = A - IDX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_e;

  state_e                 state_q, state_d;
  logic                   memValid_q, memValid_d;
  logic [A-1:0]           memAddr_q, memAddr_d;
  logic [D-1:0]           instr_q, instr_d;
  logic [15:0]            hitCount_q, hitCount_d;
  logic [15:0]            missCount_q, missCount_d;
  logic                   flushPend_q, flushPend_d;
  logic [CACHE_LINES-1:0] lineValid_q, lineValid_d;
  logic [TAG_BITS-1:0]    lineTag_q  [CACHE_LINES];
  logic [D-1:0]           lineData_q [CACHE_LINES];

  logic [IDX_BITS-1:0] lookupIdx, fillIdx;
  logic [TAG_BITS-1:0] lookupTag, fillTag;
  logic                lookupHit;
  logic                fillEn;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lookupIdx = current_pc[IDX_BITS-1:0];
  assign lookupTag = current_pc[A-1:IDX_BITS];
  assign fillIdx   = memAddr_q[IDX_BITS-1:0];
  assign fillTag   = memAddr_q[A-1:IDX_BITS];
  assign lookupHit = lineValid_q[lookupIdx] && (lineTag_q[lookupIdx] == lookupTag);

  always_comb begin
    state_d     = state_q;
    memValid_d  = memValid_q;
    memAddr_d   = memAddr_q;
    instr_d     = instr_q;
    hitCount_d  = hitCount_q;
    missCount_d = missCount_q;
    flushPend_d = 1'b0;
    lineValid_d = flush ? '0 : lineValid_q;
    fillEn      = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (lookupHit) begin
            instr_d    = lineData_q[lookupIdx];
            hitCount_d = satInc(hitCount_q);
            state_d    = FETCHED;
          end else begin
            memValid_d  = 1'b1;
            memAddr_d   = current_pc;
            missCount_d = satInc(missCount_q);
            state_d     = FETCHING;
          end
        end
      end
      FETCHING: begin
        flushPend_d = flushPend_q || flush;
        if (mem_read_ready) begin
          instr_d     = mem_read_data;
          memValid_d  = 1'b0;
          state_d     = FETCHED;
          flushPend_d = 1'b0;
          fillEn      = 1'b1;
          // A flush seen at any point of the miss leaves the filled line invalid.
          if (!(flushPend_q || flush)) begin
            lineValid_d[fillIdx] = 1'b1;
          end
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      memValid_q  <= 1'b0;
      memAddr_q   <= '0;
      instr_q     <= '0;
      hitCount_q  <= '0;
      missCount_q <= '0;
      flushPend_q <= 1'b0;
      lineValid_q <= '0;
    end else begin
      state_q     <= state_d;
      memValid_q  <= memValid_d;
      memAddr_q   <= memAddr_d;
      instr_q     <= instr_d;
      hitCount_q  <= hitCount_d;
      missCount_q <= missCount_d;
      flushPend_q <= flushPend_d;
      lineValid_q <= lineValid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fillEn) begin
      lineTag_q[fillIdx]  <= fillTag;
      lineData_q[fillIdx] <= mem_read_data;
    end
  end

  assign mem_read_valid   = memValid_q;
  assign mem_read_address = memAddr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign hit_count        = hitCount_q;
  assign miss_count       = missCount_q;

endmodule
